cache_ctrl_fsm: RTL and testbench
=================================

Name: cache_ctrl_fsm

Overview:
Control FSM for the 4-way LFU cache datapath. It accepts CPU requests through a run/done handshake and latches the address and write data. It drives every datapath enable (tag/data read, CPU/RAM write, mux select, LFU counters) and sequences RAM line refills on a read miss and write-through on every write. It also keeps hit/miss statistics.

Parameters:
TIMEOUT, 255, maximum cycles to wait for ram_ack before aborting with error.
CNT_W, 32, width of the hit/miss statistics counters.

Ports:
clk  in  1  system clock
gen_reset  in  1  asynchronous, active-high reset
run  in  1  CPU request strobe, sampled only in IDLE
RW  in  1  request type: 1=write, 0=read
address  in  48  CPU byte/word address
Data_In  in  16  CPU write data
busy  out  1  high from request acceptance until done
done  out  1  one-cycle completion pulse; read data valid on Data_Out in that cycle
error  out  1  one-cycle pulse with done when a RAM timeout occurs
addr_q  out  48  latched request address to datapath
data_q  out  16  latched write data to datapath
hit  in  1  datapath hit, valid the cycle after tag read
ram_req  out  1  RAM request, held until ram_ack
ram_we  out  1  1=word write (write-through), 0=line read
ram_addr  out  48  read: {addr_q[47:2],2'b00}; write: addr_q
ram_ack  in  1  RAM done; for reads the line is valid on Line_In in the same cycle
SelecMemCPU  out  1  0=RAM line into cache, 1=CPU word
ReadEnableTag  out  1  tag array read enable
ReadEnableData  out  1  data array read enable
cpu_write  out  1  qualifies write_enable_cpu
write_enable_cpu  out  2  word index = addr_q[1:0]
write_enable_ram  out  1  line refill write into LFU-selected way
enable_contadores  out  1  LFU counter update (increment on hit, clear on refill)
count_read  out  1  LFU count read
hit_count  out  CNT_W  read+write hits
miss_count  out  CNT_W  read+write misses

Behaviour:
- Reset (asynchronous): state=IDLE; every output 0; addr_q, data_q, statistics counters and timeout counter 0.
- IDLE: when run=1, latch address/Data_In/RW into addr_q/data_q/rw_q, set busy=1, go to LOOKUP. run=0 keeps the FSM in IDLE. run is ignored in every other state.
- LOOKUP (1 cycle): ReadEnableTag=ReadEnableData=count_read=1, then go to COMPARE.
- COMPARE: ReadEnableData and count_read stay 1.
  - hit=1: enable_contadores=1 for this cycle; hit_count+1.
    - rw_q=0: go to DONE.
    - rw_q=1: go to WR_HIT.
  - hit=0: miss_count+1.
    - rw_q=0: go to REFILL_REQ.
    - rw_q=1: go to WT_REQ (no-write-allocate).
- WR_HIT (1 cycle): SelecMemCPU=1, cpu_write=1, write_enable_cpu=addr_q[1:0], then go to WT_REQ.
- WT_REQ: ram_req=1, ram_we=1, ram_addr=addr_q. On ram_ack go to DONE.
- REFILL_REQ: ram_req=1, ram_we=0, ram_addr line-aligned, count_read=1. On ram_ack, in the same cycle assert write_enable_ram=1, SelecMemCPU=0, enable_contadores=1; then go to LOOKUP. The re-lookup hits and is counted as a hit, so one read miss adds miss+1 and hit+1.
- DONE (1 cycle): done=1, ReadEnableData=1 so Data_Out is stable, busy drops at the next edge, then go to IDLE.
- Timeout: the counter clears on entry to WT_REQ or REFILL_REQ and increments each cycle without ram_ack. When it reaches TIMEOUT-1 with no ack, drop ram_req and go to DONE with error=1. Nothing is written to the cache.
- ram_ack outside WT_REQ/REFILL_REQ is ignored.
- Statistics counters wrap modulo 2^CNT_W and are never cleared except by reset.
- gen_reset mid-transaction aborts immediately: no done pulse, ram_req drops asynchronously.
- Latency (no RAM wait):
  - read hit: done 3 cycles after run.
  - write hit: 4 cycles + RAM latency.
  - read miss: 5 cycles + RAM latency.

Test Plan:
- Reset mid-REFILL_REQ -> ram_req, busy and every enable go to 0 asynchronously; state IDLE; hit_count=miss_count=0.
- Read 0x000000001234, hit=1 in COMPARE -> enable_contadores pulses once; done pulses 3 cycles after run; hit_count=1, miss_count=0; no ram_req.
- Read miss, ram_ack 4 cycles after ram_req -> ram_addr=0x000000001234 with [1:0]=00, ram_we=0; write_enable_ram=1 with SelecMemCPU=0 in the ack cycle; LOOKUP repeats; done follows; miss_count=1, hit_count=1.
- Write hit, Data_In=0xBEEF, address[1:0]=2 -> cpu_write=1, write_enable_cpu=2, SelecMemCPU=1 for one cycle; then ram_we=1 with ram_addr=address; done on ram_ack.
- Write miss -> no cpu_write or write_enable_ram; only a write-through to RAM; miss_count+1.
- TIMEOUT=8, ram_ack never asserted -> ram_req drops after 8 cycles; done=1 and error=1 in the same cycle; back in IDLE; a new run is accepted next.

Source files
------------

// File: rtl/cache_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_fsm_if
// Description : Bundles the CPU handshake, datapath control and RAM bus
//               signals of the 4-way LFU cache control FSM.
//               master : the control FSM (drives enables, RAM request, stats)
//               slave  : the environment (CPU, datapath, RAM)
// Ports       : none (signal bundle only)
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    // CPU handshake
    logic              run;
    logic              RW;
    logic [47:0]       address;
    logic [15:0]       Data_In;
    logic              busy;
    logic              done;
    logic              error;
    // Datapath
    logic [47:0]       addr_q;
    logic [15:0]       data_q;
    logic              hit;
    logic              SelecMemCPU;
    logic              ReadEnableTag;
    logic              ReadEnableData;
    logic              cpu_write;
    logic [1:0]        write_enable_cpu;
    logic              write_enable_ram;
    logic              enable_contadores;
    logic              count_read;
    // RAM bus
    logic              ram_req;
    logic              ram_we;
    logic [47:0]       ram_addr;
    logic              ram_ack;
    // Statistics
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  run, RW, address, Data_In, hit, ram_ack,
        output busy, done, error, addr_q, data_q,
        output ram_req, ram_we, ram_addr,
        output SelecMemCPU, ReadEnableTag, ReadEnableData, cpu_write,
        output write_enable_cpu, write_enable_ram, enable_contadores, count_read,
        output hit_count, miss_count
    );

    modport slave (
        output run, RW, address, Data_In, hit, ram_ack,
        input  busy, done, error, addr_q, data_q,
        input  ram_req, ram_we, ram_addr,
        input  SelecMemCPU, ReadEnableTag, ReadEnableData, cpu_write,
        input  write_enable_cpu, write_enable_ram, enable_contadores, count_read,
        input  hit_count, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_fsm
// Description : Control FSM for the 4-way LFU cache datapath. Accepts CPU
//               requests, sequences tag lookup, write hits, write-through to
//               RAM, line refill on read miss, RAM timeout, and keeps hit/miss
//               statistics.
// Ports       : clk       - system clock
//               gen_reset - asynchronous active-high reset
//               bus       - cache_ctrl_fsm_if.master (CPU/datapath/RAM/stats)
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_fsm #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  wire logic           clk,
    input  wire logic           gen_reset,
    cache_ctrl_fsm_if.master    bus
);
    localparam int             TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  c_TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOOKUP     = 3'd1,
        S_COMPARE    = 3'd2,
        S_WR_HIT     = 3'd3,
        S_WT_REQ     = 3'd4,
        S_REFILL_REQ = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [47:0]        r_addr_q;
    logic [15:0]        r_data_q;
    logic               r_rw;
    logic               r_err;
    logic [TW-1:0]      r_tcnt;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic               w_wait;
    logic               w_timeout;
    logic               w_busy, w_done, w_error;
    logic               w_ram_req, w_ram_we;
    logic [47:0]        w_ram_addr;
    logic               w_sel, w_rd_tag, w_rd_data, w_cpu_write;
    logic [1:0]         w_we_cpu;
    logic               w_we_ram, w_en_cnt, w_cnt_rd;

    assign w_wait    = (r_state == S_WT_REQ) || (r_state == S_REFILL_REQ);
    // An ack in the last allowed cycle still wins over the timeout.
    assign w_timeout = w_wait && !bus.ram_ack && (r_tcnt == c_TO_LAST);

    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge gen_reset) begin
        if (gen_reset) begin
            r_addr_q   <= '0;
            r_data_q   <= '0;
            r_rw       <= 1'b0;
            r_err      <= 1'b0;
            r_tcnt     <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && bus.run) begin
                r_addr_q <= bus.address;
                r_data_q <= bus.Data_In;
                r_rw     <= bus.RW;
                r_err    <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            // Held at zero outside the RAM wait states, so it is clear on entry.
            if (w_wait && !bus.ram_ack) begin
                r_tcnt <= r_tcnt + TW'(1);
            end else begin
                r_tcnt <= '0;
            end
            if (r_state == S_COMPARE) begin
                if (bus.hit) begin
                    r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                end else begin
                    r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_busy      = (r_state != S_IDLE);
        w_done      = 1'b0;
        w_error     = 1'b0;
        w_ram_req   = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_sel       = 1'b0;
        w_rd_tag    = 1'b0;
        w_rd_data   = 1'b0;
        w_cpu_write = 1'b0;
        w_we_cpu    = 2'b00;
        w_we_ram    = 1'b0;
        w_en_cnt    = 1'b0;
        w_cnt_rd    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_rd_tag  = 1'b1;
                w_rd_data = 1'b1;
                w_cnt_rd  = 1'b1;
                w_next    = S_COMPARE;
            end
            S_COMPARE: begin
                w_rd_data = 1'b1;
                w_cnt_rd  = 1'b1;
                if (bus.hit) begin
                    w_en_cnt = 1'b1;
                    w_next   = r_rw ? S_WR_HIT : S_DONE;
                end else begin
                    // Write miss: no-write-allocate, straight to write-through.
                    w_next   = r_rw ? S_WT_REQ : S_REFILL_REQ;
                end
            end
            S_WR_HIT: begin
                w_sel       = 1'b1;
                w_cpu_write = 1'b1;
                w_we_cpu    = r_addr_q[1:0];
                w_next      = S_WT_REQ;
            end
            S_WT_REQ: begin
                w_ram_req  = 1'b1;
                w_ram_we   = 1'b1;
                w_ram_addr = r_addr_q;
                if (bus.ram_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_REFILL_REQ: begin
                w_ram_req  = 1'b1;
                w_ram_addr = {r_addr_q[47:2], 2'b00};
                w_cnt_rd   = 1'b1;
                if (bus.ram_ack) begin
                    // Line is on Line_In now; write it and reset its LFU count,
                    // then re-run the lookup which will hit.
                    w_we_ram = 1'b1;
                    w_en_cnt = 1'b1;
                    w_next   = S_LOOKUP;
                end else if (w_timeout) begin
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                w_done    = 1'b1;
                w_error   = r_err;
                w_rd_data = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.busy              = w_busy;
    assign bus.done              = w_done;
    assign bus.error             = w_error;
    assign bus.addr_q            = r_addr_q;
    assign bus.data_q            = r_data_q;
    assign bus.ram_req           = w_ram_req;
    assign bus.ram_we            = w_ram_we;
    assign bus.ram_addr          = w_ram_addr;
    assign bus.SelecMemCPU       = w_sel;
    assign bus.ReadEnableTag     = w_rd_tag;
    assign bus.ReadEnableData    = w_rd_data;
    assign bus.cpu_write         = w_cpu_write;
    assign bus.write_enable_cpu  = w_we_cpu;
    assign bus.write_enable_ram  = w_we_ram;
    assign bus.enable_contadores = w_en_cnt;
    assign bus.count_read        = w_cnt_rd;
    assign bus.hit_count         = r_hit_cnt;
    assign bus.miss_count        = r_miss_cnt;
endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_fsm
// Description : Directed self-checking bench for cache_ctrl_fsm (TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_fsm;
    localparam int c_TIMEOUT = 8;
    localparam int c_CNT_W   = 32;

    logic clk;
    logic gen_reset;
    int   n_assert;
    int   n_fail;

    cache_ctrl_fsm_if #(.CNT_W(c_CNT_W)) bus ();

    cache_ctrl_fsm #(
        .TIMEOUT (c_TIMEOUT),
        .CNT_W   (c_CNT_W)
    ) u_dut (
        .clk       (clk),
        .gen_reset (gen_reset),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs checked off the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        gen_reset            = 1'b1;
        bus.run              = 1'b0;
        bus.RW               = 1'b0;
        bus.address          = '0;
        bus.Data_In          = '0;
        bus.hit              = 1'b0;
        bus.ram_ack          = 1'b0;
        step(); step();
        #1;
        chk("rst_busy",    64'(bus.busy), 64'h0);
        chk("rst_done",    64'(bus.done), 64'h0);
        chk("rst_ram_req", 64'(bus.ram_req), 64'h0);
        chk("rst_rd_tag",  64'(bus.ReadEnableTag), 64'h0);
        chk("rst_addr_q",  64'(bus.addr_q), 64'h0);
        chk("rst_hits",    64'(bus.hit_count), 64'h0);
        gen_reset = 1'b0;
        step();

        // ---------------- read hit ----------------
        bus.run = 1'b1; bus.RW = 1'b0; bus.address = 48'h0000_0000_1234;
        step();                                   // LOOKUP
        bus.run = 1'b0; #1;
        chk("rh_busy",    64'(bus.busy), 64'h1);
        chk("rh_rd_tag",  64'(bus.ReadEnableTag), 64'h1);
        chk("rh_addr_q",  64'(bus.addr_q), 64'h1234);
        chk("rh_done_lk", 64'(bus.done), 64'h0);
        step();                                   // COMPARE
        bus.hit = 1'b1; #1;
        chk("rh_en_cnt",  64'(bus.enable_contadores), 64'h1);
        chk("rh_rd_data", 64'(bus.ReadEnableData), 64'h1);
        chk("rh_ram_req", 64'(bus.ram_req), 64'h0);
        step();                                   // DONE
        bus.hit = 1'b0; #1;
        chk("rh_done",    64'(bus.done), 64'h1);
        chk("rh_error",   64'(bus.error), 64'h0);
        chk("rh_en_cnt0", 64'(bus.enable_contadores), 64'h0);
        chk("rh_hits",    64'(bus.hit_count), 64'h1);
        chk("rh_miss",    64'(bus.miss_count), 64'h0);
        step();                                   // IDLE
        chk("rh_idle_busy", 64'(bus.busy), 64'h0);
        chk("rh_idle_done", 64'(bus.done), 64'h0);

        // ---------------- read miss, ack after 4 cycles ----------------
        bus.run = 1'b1; bus.RW = 1'b0; bus.address = 48'h0000_0000_1236;
        step();                                   // LOOKUP
        bus.run = 1'b0;
        step();                                   // COMPARE, miss
        #1;
        chk("rm_en_cnt0", 64'(bus.enable_contadores), 64'h0);
        step();                                   // REFILL_REQ cycle 0
        chk("rm_ram_req",  64'(bus.ram_req), 64'h1);
        chk("rm_ram_we",   64'(bus.ram_we), 64'h0);
        chk("rm_ram_addr", 64'(bus.ram_addr), 64'h1234);
        chk("rm_cnt_rd",   64'(bus.count_read), 64'h1);
        chk("rm_miss",     64'(bus.miss_count), 64'h1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("rm_wait_req", 64'(bus.ram_req), 64'h1);
            chk("rm_wait_wer", 64'(bus.write_enable_ram), 64'h0);
        end
        step();                                   // cycle 4: ack
        bus.ram_ack = 1'b1; #1;
        chk("rm_we_ram",  64'(bus.write_enable_ram), 64'h1);
        chk("rm_sel",     64'(bus.SelecMemCPU), 64'h0);
        chk("rm_en_cnt",  64'(bus.enable_contadores), 64'h1);
        step();                                   // LOOKUP again
        bus.ram_ack = 1'b0; #1;
        chk("rm_relookup", 64'(bus.ReadEnableTag), 64'h1);
        chk("rm_req_off",  64'(bus.ram_req), 64'h0);
        step();                                   // COMPARE, hit
        bus.hit = 1'b1;
        step();                                   // DONE
        bus.hit = 1'b0; #1;
        chk("rm_done",  64'(bus.done), 64'h1);
        chk("rm_error", 64'(bus.error), 64'h0);
        chk("rm_hits",  64'(bus.hit_count), 64'h2);
        chk("rm_miss2", 64'(bus.miss_count), 64'h1);
        step();                                   // IDLE

        // ---------------- write hit ----------------
        bus.run = 1'b1; bus.RW = 1'b1; bus.address = 48'h0000_0000_ABCE; bus.Data_In = 16'hBEEF;
        step();                                   // LOOKUP
        bus.run = 1'b0; bus.RW = 1'b0; bus.Data_In = 16'h0000; #1;
        chk("wh_data_q", 64'(bus.data_q), 64'hBEEF);
        step();                                   // COMPARE
        bus.hit = 1'b1;
        step();                                   // WR_HIT
        bus.hit = 1'b0; #1;
        chk("wh_cpu_write", 64'(bus.cpu_write), 64'h1);
        chk("wh_we_cpu",    64'(bus.write_enable_cpu), 64'h2);
        chk("wh_sel",       64'(bus.SelecMemCPU), 64'h1);
        chk("wh_ram_req0",  64'(bus.ram_req), 64'h0);
        chk("wh_hits",      64'(bus.hit_count), 64'h3);
        step();                                   // WT_REQ
        chk("wh_cpu_write0", 64'(bus.cpu_write), 64'h0);
        chk("wh_sel0",       64'(bus.SelecMemCPU), 64'h0);
        chk("wh_ram_req",    64'(bus.ram_req), 64'h1);
        chk("wh_ram_we",     64'(bus.ram_we), 64'h1);
        chk("wh_ram_addr",   64'(bus.ram_addr), 64'hABCE);
        step();
        bus.ram_ack = 1'b1;
        step();                                   // DONE
        bus.ram_ack = 1'b0; #1;
        chk("wh_done",  64'(bus.done), 64'h1);
        chk("wh_error", 64'(bus.error), 64'h0);
        step();

        // ---------------- write miss ----------------
        bus.run = 1'b1; bus.RW = 1'b1; bus.address = 48'h0000_5555_0001; bus.Data_In = 16'h1357;
        step();                                   // LOOKUP
        bus.run = 1'b0; bus.RW = 1'b0;
        step();                                   // COMPARE miss
        #1;
        chk("wm_cpu_write_c", 64'(bus.cpu_write), 64'h0);
        step();                                   // WT_REQ
        chk("wm_cpu_write", 64'(bus.cpu_write), 64'h0);
        chk("wm_we_ram",    64'(bus.write_enable_ram), 64'h0);
        chk("wm_ram_we",    64'(bus.ram_we), 64'h1);
        chk("wm_ram_addr",  64'(bus.ram_addr), 64'h0000_5555_0001);
        chk("wm_miss",      64'(bus.miss_count), 64'h2);
        bus.ram_ack = 1'b1; #1;
        chk("wm_we_ram_ack", 64'(bus.write_enable_ram), 64'h0);
        step();                                   // DONE
        bus.ram_ack = 1'b0; #1;
        chk("wm_done",  64'(bus.done), 64'h1);
        chk("wm_hits",  64'(bus.hit_count), 64'h3);
        step();

        // ---------------- timeout on refill ----------------
        bus.run = 1'b1; bus.RW = 1'b0; bus.address = 48'h0000_0000_0040;
        step();                                   // LOOKUP
        bus.run = 1'b0;
        step();                                   // COMPARE miss
        step();                                   // REFILL_REQ cycle 0
        chk("to_req0", 64'(bus.ram_req), 64'h1);
        for (int i = 1; i < c_TIMEOUT; i++) begin
            step();
            chk("to_req_held", 64'(bus.ram_req), 64'h1);
        end
        step();                                   // DONE with error
        chk("to_ram_req", 64'(bus.ram_req), 64'h0);
        chk("to_done",    64'(bus.done), 64'h1);
        chk("to_error",   64'(bus.error), 64'h1);
        chk("to_we_ram",  64'(bus.write_enable_ram), 64'h0);
        chk("to_miss",    64'(bus.miss_count), 64'h3);
        step();                                   // IDLE
        chk("to_idle_busy",  64'(bus.busy), 64'h0);
        chk("to_idle_error", 64'(bus.error), 64'h0);
        // new request accepted right away
        bus.run = 1'b1; bus.RW = 1'b0; bus.address = 48'h0000_0000_0044;
        step();                                   // LOOKUP
        bus.run = 1'b0; #1;
        chk("to_new_busy", 64'(bus.busy), 64'h1);
        chk("to_new_addr", 64'(bus.addr_q), 64'h44);
        step();                                   // COMPARE
        bus.hit = 1'b1;
        step();                                   // DONE
        bus.hit = 1'b0; #1;
        chk("to_new_done",  64'(bus.done), 64'h1);
        chk("to_new_error", 64'(bus.error), 64'h0);
        chk("to_new_hits",  64'(bus.hit_count), 64'h4);
        step();

        // ---------------- reset in the middle of a refill ----------------
        bus.run = 1'b1; bus.RW = 1'b0; bus.address = 48'h0000_0000_0080;
        step();
        bus.run = 1'b0;
        step();                                   // COMPARE miss
        step();                                   // REFILL_REQ
        chk("mr_req_before", 64'(bus.ram_req), 64'h1);
        #1;                                       // between clock edges
        gen_reset = 1'b1;
        #1;
        chk("mr_ram_req",   64'(bus.ram_req), 64'h0);
        chk("mr_busy",      64'(bus.busy), 64'h0);
        chk("mr_cnt_rd",    64'(bus.count_read), 64'h0);
        chk("mr_rd_data",   64'(bus.ReadEnableData), 64'h0);
        chk("mr_hits",      64'(bus.hit_count), 64'h0);
        chk("mr_miss",      64'(bus.miss_count), 64'h0);
        chk("mr_addr_q",    64'(bus.addr_q), 64'h0);
        step();
        gen_reset = 1'b0;
        step();
        chk("mr_idle_busy", 64'(bus.busy), 64'h0);
        chk("mr_idle_done", 64'(bus.done), 64'h0);
        chk("mr_idle_req",  64'(bus.ram_req), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
